// File: rtl/vector_norm_unit.sv
// vector_norm_unit: sequential vector engine returning |a|^2, a.b or floor(sqrt(|a|^2)).
// One multiply-accumulate per cycle, then an optional bit-serial restoring sqrt.
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready  request handshake; mode, a_vec, b_vec sampled on accept
//   mode                 00 sum-sq, 01 dot, 10 norm, 11 illegal
//   a_vec, b_vec         packed signed vectors, element i at [i*DATA_W +: DATA_W]
//   abort                synchronous cancel of the current operation
//   out_valid/out_ready  result handshake; result and err held until accepted
//   result               signed ACC_W result (norm zero-extended)
//   err                  illegal-mode flag, qualified by out_valid
module vector_norm_unit #(
   parameter int unsigned VECTOR_LEN = 4,
   parameter int unsigned DATA_W     = 8,
   localparam int unsigned ACC_W     = 2*DATA_W + $clog2(VECTOR_LEN) + 1
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [1:0]                     mode,
   input  logic [VECTOR_LEN*DATA_W-1:0]   a_vec,
   input  logic [VECTOR_LEN*DATA_W-1:0]   b_vec,
   input  logic                           abort,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic signed [ACC_W-1:0]        result,
   output logic                           err
);

   localparam int unsigned VEC_W  = VECTOR_LEN*DATA_W;
   localparam int unsigned SQRT_W = (ACC_W+1)/2;
   localparam int unsigned RAD_W  = 2*SQRT_W;
   localparam int unsigned REM_W  = SQRT_W+2;
   localparam int unsigned PROD_W = 2*DATA_W;
   localparam int unsigned IDX_W  = (VECTOR_LEN > 1) ? $clog2(VECTOR_LEN) : 1;
   localparam int unsigned CNT_W  = $clog2(SQRT_W+1);

   typedef enum logic [1:0] {IDLE, MAC, SQRT, DONE} state_t;

   state_t                    state_q, state_n;
   logic [1:0]                mode_q, mode_n;
   logic [VEC_W-1:0]          a_q, a_n, b_q, b_n;
   logic signed [ACC_W-1:0]   acc_q, acc_n;
   logic [IDX_W-1:0]          idx_q, idx_n;
   logic [RAD_W-1:0]          rad_q, rad_n;
   logic [REM_W-1:0]          rem_q, rem_n;
   logic [SQRT_W-1:0]         root_q, root_n;
   logic [CNT_W-1:0]          cnt_q, cnt_n;
   logic signed [ACC_W-1:0]   result_q, result_n;
   logic                      err_q, err_n;
   logic                      in_ready_q, in_ready_n;
   logic                      out_valid_q, out_valid_n;

   logic signed [DATA_W-1:0]  a_el, m_el;
   logic signed [PROD_W-1:0]  prod;
   logic [REM_W-1:0]          rem_sh, trial;

   // Current MAC operands: a[idx] times either b[idx] (dot) or a[idx] (squares)
   always_comb begin
      a_el = a_q[int'(idx_q)*DATA_W +: DATA_W];
      m_el = (mode_q == 2'b01) ? b_q[int'(idx_q)*DATA_W +: DATA_W] : a_el;
      prod = PROD_W'(a_el) * PROD_W'(m_el);
   end

   // One restoring sqrt digit: bring down two radicand bits, try subtracting 4*root+1
   always_comb begin
      rem_sh = {rem_q[SQRT_W-1:0], rad_q[RAD_W-1 -: 2]};
      trial  = {root_q, 2'b01};
   end

   // Next-state and datapath updates
   always_comb begin
      state_n  = state_q;
      mode_n   = mode_q;
      a_n      = a_q;
      b_n      = b_q;
      acc_n    = acc_q;
      idx_n    = idx_q;
      rad_n    = rad_q;
      rem_n    = rem_q;
      root_n   = root_q;
      cnt_n    = cnt_q;
      result_n = result_q;
      err_n    = err_q;

      if (abort && state_q != IDLE) begin
         state_n = IDLE;
         err_n   = 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (in_valid && in_ready_q && !abort) begin
                  mode_n = mode;
                  a_n    = a_vec;
                  b_n    = b_vec;
                  acc_n  = '0;
                  idx_n  = '0;
                  if (mode == 2'b11) begin
                     state_n  = DONE;
                     result_n = '0;
                     err_n    = 1'b1;
                  end else begin
                     state_n = MAC;
                  end
               end
            end
            MAC: begin
               acc_n = acc_q + ACC_W'(prod);
               idx_n = idx_q + IDX_W'(1);
               if (idx_q == IDX_W'(VECTOR_LEN-1)) begin
                  if (mode_q == 2'b10) begin
                     state_n = SQRT;
                     rad_n   = RAD_W'($unsigned(acc_n));
                     rem_n   = '0;
                     root_n  = '0;
                     cnt_n   = '0;
                  end else begin
                     state_n  = DONE;
                     result_n = acc_n;
                     err_n    = 1'b0;
                  end
               end
            end
            SQRT: begin
               rad_n = rad_q << 2;
               if (rem_sh >= trial) begin
                  rem_n  = rem_sh - trial;
                  root_n = {root_q[SQRT_W-2:0], 1'b1};
               end else begin
                  rem_n  = rem_sh;
                  root_n = {root_q[SQRT_W-2:0], 1'b0};
               end
               cnt_n = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(SQRT_W-1)) begin
                  state_n  = DONE;
                  result_n = ACC_W'(root_n);
                  err_n    = 1'b0;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state_n = IDLE;
                  err_n   = 1'b0;
               end
            end
            default: state_n = IDLE;
         endcase
      end

      in_ready_n  = (state_n == IDLE);
      out_valid_n = (state_n == DONE);
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         mode_q      <= '0;
         a_q         <= '0;
         b_q         <= '0;
         acc_q       <= '0;
         idx_q       <= '0;
         rad_q       <= '0;
         rem_q       <= '0;
         root_q      <= '0;
         cnt_q       <= '0;
         result_q    <= '0;
         err_q       <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_n;
         mode_q      <= mode_n;
         a_q         <= a_n;
         b_q         <= b_n;
         acc_q       <= acc_n;
         idx_q       <= idx_n;
         rad_q       <= rad_n;
         rem_q       <= rem_n;
         root_q      <= root_n;
         cnt_q       <= cnt_n;
         result_q    <= result_n;
         err_q       <= err_n;
         in_ready_q  <= in_ready_n;
         out_valid_q <= out_valid_n;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign err       = err_q;

endmodule

// File: tb/tb_vector_norm_unit.sv
// tb_vector_norm_unit: directed and randomized checks of vector_norm_unit against an
// arithmetic reference model (sum of squares, dot product, integer square root).
module tb_vector_norm_unit;

   localparam int unsigned VL     = 4;
   localparam int unsigned DW     = 8;
   localparam int unsigned ACC_W  = 2*DW + $clog2(VL) + 1;
   localparam int unsigned SQRT_W = (ACC_W+1)/2;

   logic                     clk;
   logic                     rst_n;
   logic                     in_valid;
   logic                     in_ready;
   logic [1:0]               mode;
   logic [VL*DW-1:0]         a_vec;
   logic [VL*DW-1:0]         b_vec;
   logic                     abort;
   logic                     out_valid;
   logic                     out_ready;
   logic signed [ACC_W-1:0]  result;
   logic                     err;

   int checks   = 0;
   int failures = 0;

   vector_norm_unit #(.VECTOR_LEN(VL), .DATA_W(DW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .mode      (mode),
      .a_vec     (a_vec),
      .b_vec     (b_vec),
      .abort     (abort),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .err       (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic signed [63:0] obs,
                      input logic signed [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic logic [VL*DW-1:0] pack4(input int e0, input int e1,
                                              input int e2, input int e3);
      return {DW'(e3), DW'(e2), DW'(e1), DW'(e0)};
   endfunction

   // Reference: plain integer arithmetic on the sign-extended elements
   function automatic longint model(input logic [1:0] m, input logic [VL*DW-1:0] a,
                                    input logic [VL*DW-1:0] b);
      longint s = 0;
      longint r = 0;
      longint ai, bi;
      if (m == 2'b11) return 0;
      for (int i = 0; i < VL; i++) begin
         ai = $signed(a[i*DW +: DW]);
         bi = $signed(b[i*DW +: DW]);
         s += (m == 2'b01) ? ai*bi : ai*ai;
      end
      if (m != 2'b10) return s;
      while ((r+1)*(r+1) <= s) r++;
      return r;
   endfunction

   function automatic int latency(input logic [1:0] m);
      // edges after the accept edge until out_valid is seen high
      case (m)
         2'b11:   return 0;
         2'b10:   return VL + SQRT_W;
         default: return VL;
      endcase
   endfunction

   // Present one request and let the accept edge happen; inputs are then scrambled
   task automatic start_op(input string tag, input logic [1:0] m,
                           input logic [VL*DW-1:0] a, input logic [VL*DW-1:0] b);
      int n = 0;
      while (!in_ready && n < 50) begin step(); n++; end
      chk({tag, "_in_ready"}, in_ready, 1);
      mode = m; a_vec = a; b_vec = b; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      mode = 2'($urandom); a_vec = $urandom; b_vec = $urandom;
   endtask

   task automatic wait_done(input string tag, input logic [1:0] m,
                            input logic [VL*DW-1:0] a, input logic [VL*DW-1:0] b);
      int n = 0;
      while (!out_valid && n < 100) begin step(); n++; end
      chk({tag, "_latency"}, n, latency(m));
      chk({tag, "_result"}, result, model(m, a, b));
      chk({tag, "_err"}, err, (m == 2'b11));
   endtask

   task automatic finish_op(input string tag, input int delay);
      repeat (delay) step();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk({tag, "_out_valid_drop"}, out_valid, 0);
   endtask

   task automatic run_op(input string tag, input logic [1:0] m,
                         input logic [VL*DW-1:0] a, input logic [VL*DW-1:0] b,
                         input int delay);
      start_op(tag, m, a, b);
      wait_done(tag, m, a, b);
      finish_op(tag, delay);
   endtask

   initial begin
      logic [VL*DW-1:0] va, vb;
      int hi;
      rst_n = 1'b0; in_valid = 1'b0; mode = 2'b00; a_vec = '0; b_vec = '0;
      abort = 1'b0; out_ready = 1'b0;
      #12;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_result", result, 0);
      chk("rst_err", err, 0);
      rst_n = 1'b1;
      step();

      // Directed arithmetic cases
      va = pack4(3, -4, 0, 0);
      run_op("sumsq_3_4", 2'b00, va, '0, 0);
      run_op("norm_3_4", 2'b10, va, '0, 1);
      va = pack4(-128, -128, -128, -128);
      run_op("norm_max", 2'b10, va, '0, 0);
      va = pack4(127, -128, 1, 2);
      vb = pack4(-128, -128, 5, -7);
      run_op("dot_mixed", 2'b01, va, vb, 2);
      va = pack4(-128, -128, -128, -128);
      vb = pack4(127, 127, 127, 127);
      run_op("dot_min", 2'b01, va, vb, 0);
      run_op("illegal", 2'b11, va, vb, 0);

      // Back-pressure in DONE with a pending request that must not be taken
      va = pack4(3, -4, 0, 0);
      start_op("hold", 2'b00, va, '0);
      wait_done("hold", 2'b00, va, '0);
      mode = 2'b00; a_vec = pack4(1, 1, 1, 1); in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         chk("hold_out_valid", out_valid, 1);
         chk("hold_result", result, 25);
         chk("hold_in_ready", in_ready, 0);
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("hold_release_valid", out_valid, 0);
      chk("hold_release_ready", in_ready, 1);
      step();
      in_valid = 1'b0;
      chk("hold_accept_next", in_ready, 0);
      wait_done("hold_next", 2'b00, pack4(1, 1, 1, 1), '0);
      finish_op("hold_next", 0);

      // Abort during the square-root phase
      start_op("abort", 2'b10, pack4(3, -4, 0, 0), '0);
      repeat (VL + 3) step();
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("abort_in_ready", in_ready, 1);
      chk("abort_out_valid", out_valid, 0);
      hi = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (out_valid) hi++;
      end
      chk("abort_no_result", hi, 0);

      // Abort while idle blocks acceptance
      abort = 1'b1; in_valid = 1'b1; mode = 2'b00;
      step();
      abort = 1'b0; in_valid = 1'b0;
      chk("abort_idle_block", in_ready, 1);

      // Asynchronous reset in the middle of accumulation
      start_op("rst_mid", 2'b01, pack4(5, 6, 7, 8), pack4(1, 2, 3, 4));
      step();
      step();
      rst_n = 1'b0;
      #1;
      chk("rst_mid_in_ready", in_ready, 1);
      chk("rst_mid_out_valid", out_valid, 0);
      chk("rst_mid_result", result, 0);
      chk("rst_mid_err", err, 0);
      #3;
      rst_n = 1'b1;
      step();

      // Back-to-back illegal requests: one result every other cycle
      mode = 2'b11; in_valid = 1'b1; out_ready = 1'b1;
      step();
      for (int i = 0; i < 8; i++) begin
         chk("b2b_out_valid", out_valid, (i % 2 == 0));
         if (i % 2 == 0) chk("b2b_err", err, 1);
         step();
      end
      in_valid = 1'b0;
      step();
      step();
      out_ready = 1'b0;

      // Randomized operations
      for (int i = 0; i < 24; i++) begin
         run_op("rnd", 2'($urandom_range(0, 3)), $urandom, $urandom,
                int'($urandom_range(0, 3)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
